data_memory: RTL and testbench



---
 rtl/data_memory.sv | 157 +++++++++++++++
 tb/tb_data_memory.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Hack CPU data-bus responder: internal RAM, a screen framebuffer behind a
// req/ack video port with a one-word read cache, and a read-only keyboard word.
module data_memory #(
    parameter int RAM_WORDS = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mem_address,
    input  logic        mem_write,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_busy,
    input  logic [15:0] kbd_code,
    output logic        vid_req,
    output logic        vid_we,
    output logic [12:0] vid_addr,
    output logic [15:0] vid_wdata,
    input  logic [15:0] vid_rdata,
    input  logic        vid_ack
);

    localparam int          AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [16:0] RAM_LIMIT = 17'(RAM_WORDS);

    typedef enum logic [1:0] {IDLE, VID_RD, VID_WR} state_t;

    logic [15:0] ram [RAM_WORDS];

    state_t      state_q, state_d;
    logic [15:0] mem_rdata_q, mem_rdata_d;
    logic        mem_busy_q, mem_busy_d;
    logic        vid_req_q, vid_req_d;
    logic        vid_we_q, vid_we_d;
    logic [12:0] vid_addr_q, vid_addr_d;
    logic [15:0] vid_wdata_q, vid_wdata_d;
    logic [12:0] c_addr_q, c_addr_d;
    logic [15:0] c_data_q, c_data_d;
    logic        c_valid_q, c_valid_d;

    logic        in_ram, is_screen, is_kbd, cache_hit, ram_we;
    logic [15:0] ram_rdata;

    always_comb begin
        in_ram    = ({1'b0, mem_address} < RAM_LIMIT);
        is_screen = (mem_address[15:13] == 3'b010);
        is_kbd    = (mem_address == 16'h6000);
        cache_hit = c_valid_q && (c_addr_q == mem_address[12:0]);
        ram_rdata = ram[mem_address[AW-1:0]];

        state_d     = state_q;
        mem_rdata_d = mem_rdata_q;
        mem_busy_d  = mem_busy_q;
        vid_req_d   = vid_req_q;
        vid_we_d    = vid_we_q;
        vid_addr_d  = vid_addr_q;
        vid_wdata_d = vid_wdata_q;
        c_addr_d    = c_addr_q;
        c_data_d    = c_data_q;
        c_valid_d   = c_valid_q;
        ram_we      = 1'b0;

        case (state_q)
            IDLE: begin
                ram_we = mem_write && in_ram && !reset;
                // A screen write is posted: the cache takes the new word at once,
                // so the read captured in this same edge sees it as a hit.
                if (mem_write && is_screen) begin
                    c_addr_d    = mem_address[12:0];
                    c_data_d    = mem_wdata;
                    c_valid_d   = 1'b1;
                    mem_rdata_d = mem_wdata;
                    vid_addr_d  = mem_address[12:0];
                    vid_wdata_d = mem_wdata;
                    vid_we_d    = 1'b1;
                    vid_req_d   = 1'b1;
                    mem_busy_d  = 1'b1;
                    state_d     = VID_WR;
                end else if (in_ram) begin
                    mem_rdata_d = ram_rdata;
                end else if (is_kbd) begin
                    mem_rdata_d = kbd_code;
                end else if (is_screen) begin
                    if (cache_hit) begin
                        mem_rdata_d = c_data_q;
                    end else begin
                        vid_addr_d = mem_address[12:0];
                        vid_we_d   = 1'b0;
                        vid_req_d  = 1'b1;
                        mem_busy_d = 1'b1;
                        state_d    = VID_RD;
                    end
                end else begin
                    mem_rdata_d = 16'h0000;
                end
            end
            VID_RD: begin
                if (vid_ack) begin
                    mem_rdata_d = vid_rdata;
                    c_addr_d    = vid_addr_q;
                    c_data_d    = vid_rdata;
                    c_valid_d   = 1'b1;
                    vid_req_d   = 1'b0;
                    mem_busy_d  = 1'b0;
                    state_d     = IDLE;
                end
            end
            VID_WR: begin
                if (vid_ack) begin
                    vid_req_d  = 1'b0;
                    mem_busy_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[mem_address[AW-1:0]] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_rdata_q <= 16'h0000;
            mem_busy_q  <= 1'b0;
            vid_req_q   <= 1'b0;
            vid_we_q    <= 1'b0;
            vid_addr_q  <= 13'h0000;
            vid_wdata_q <= 16'h0000;
            c_addr_q    <= 13'h0000;
            c_data_q    <= 16'h0000;
            c_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_rdata_q <= mem_rdata_d;
            mem_busy_q  <= mem_busy_d;
            vid_req_q   <= vid_req_d;
            vid_we_q    <= vid_we_d;
            vid_addr_q  <= vid_addr_d;
            vid_wdata_q <= vid_wdata_d;
            c_addr_q    <= c_addr_d;
            c_data_q    <= c_data_d;
            c_valid_q   <= c_valid_d;
        end
    end

    assign mem_rdata = mem_rdata_q;
    assign mem_busy  = mem_busy_q;
    assign vid_req   = vid_req_q;
    assign vid_we    = vid_we_q;
    assign vid_addr  = vid_addr_q;
    assign vid_wdata = vid_wdata_q;

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: a framebuffer responder model with programmable ack
// delay, and a queue of expected read words checked as each read completes.
module tb_data_memory;

    logic        clk;
    logic        reset;
    logic [15:0] mem_address;
    logic        mem_write;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_busy;
    logic [15:0] kbd_code;
    logic        vid_req;
    logic        vid_we;
    logic [12:0] vid_addr;
    logic [15:0] vid_wdata;
    logic [15:0] vid_rdata;
    logic        vid_ack;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];
    logic [15:0] fb [8192];
    int          ack_delay;
    int          ack_cnt;
    int          req_pulses;
    logic        req_prev;

    data_memory #(.RAM_WORDS(4096)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_address(mem_address),
        .mem_write  (mem_write),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_busy   (mem_busy),
        .kbd_code   (kbd_code),
        .vid_req    (vid_req),
        .vid_we     (vid_we),
        .vid_addr   (vid_addr),
        .vid_wdata  (vid_wdata),
        .vid_rdata  (vid_rdata),
        .vid_ack    (vid_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Framebuffer model: acks ack_delay cycles into a request, counting the
    // request's first cycle, and counts distinct request pulses.
    always @(negedge clk) begin
        if (vid_req && !req_prev) req_pulses++;
        req_prev = vid_req;
        if (vid_ack) begin
            vid_ack = 1'b0;
            ack_cnt = 0;
        end else if (vid_req) begin
            ack_cnt++;
            if (ack_cnt >= ack_delay) begin
                vid_ack = 1'b1;
                if (vid_we) fb[vid_addr] = vid_wdata;
                else        vid_rdata = fb[vid_addr];
            end
        end else begin
            ack_cnt = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_read(input logic [15:0] addr, output int busy_cycles,
                              output logic timed_out, output logic [12:0] seen_addr,
                              output logic seen_we);
        mem_address = addr;
        mem_write   = 1'b0;
        tick();
        seen_addr   = vid_addr;
        seen_we     = vid_we;
        busy_cycles = 0;
        timed_out   = 1'b0;
        while (mem_busy) begin
            if (busy_cycles >= 200) begin
                timed_out = 1'b1;
                break;
            end
            tick();
            busy_cycles++;
        end
    endtask

    task automatic issue_write(input logic [15:0] addr, input logic [15:0] data);
        mem_address = addr;
        mem_wdata   = data;
        mem_write   = 1'b1;
        tick();
        mem_write   = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (mem_rdata !== 16'h0) begin bad++; $display("[TB] FAIL rst_rdata: got %h want 0000", mem_rdata); end
        total++; if (mem_busy  !== 1'b0)  begin bad++; $display("[TB] FAIL rst_busy: got %b want 0", mem_busy); end
        total++; if (vid_req   !== 1'b0)  begin bad++; $display("[TB] FAIL rst_req: got %b want 0", vid_req); end
        total++; if (vid_we    !== 1'b0)  begin bad++; $display("[TB] FAIL rst_we: got %b want 0", vid_we); end
        total++; if (vid_addr  !== 13'h0) begin bad++; $display("[TB] FAIL rst_vaddr: got %h want 0000", vid_addr); end
        total++; if (vid_wdata !== 16'h0) begin bad++; $display("[TB] FAIL rst_vwdata: got %h want 0000", vid_wdata); end
    endtask

    task automatic test_ram();
        logic [15:0] addrs [4] = '{16'h0010, 16'h0123, 16'h0FFF, 16'h0001};
        logic [15:0] datas [4] = '{16'h1234, 16'hC0DE, 16'h7E57, 16'h0F00};
        logic [15:0] exp;
        int          bc;
        logic        to, we_s;
        logic [12:0] a_s;
        for (int i = 0; i < 4; i++) begin
            issue_write(addrs[i], datas[i]);
            total++; if (mem_busy !== 1'b0) begin bad++; $display("[TB] FAIL ram_wr_busy: got %b want 0", mem_busy); end
        end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(datas[i]);
            issue_read(addrs[i], bc, to, a_s, we_s);
            exp = exp_q.pop_front();
            total++; if (to || bc != 0) begin bad++; $display("[TB] FAIL ram_rd_busy: got %0d busy cycles want 0", bc); end
            total++; if (mem_rdata !== exp) begin bad++; $display("[TB] FAIL ram_rd: got %h want %h", mem_rdata, exp); end
        end
        // Read-first: the write edge returns the old word.
        exp_q.push_back(16'h1234);
        issue_write(16'h0010, 16'h5678);
        exp = exp_q.pop_front();
        total++; if (mem_rdata !== exp) begin bad++; $display("[TB] FAIL ram_read_first: got %h want %h", mem_rdata, exp); end
        exp_q.push_back(16'h5678);
        issue_read(16'h0010, bc, to, a_s, we_s);
        exp = exp_q.pop_front();
        total++; if (mem_rdata !== exp) begin bad++; $display("[TB] FAIL ram_rewrite: got %h want %h", mem_rdata, exp); end
    endtask

    task automatic test_kbd_unmapped();
        logic [15:0] exp;
        int          bc;
        logic        to, we_s;
        logic [12:0] a_s;
        kbd_code = 16'h0041;
        exp_q.push_back(16'h0041);
        issue_read(16'h6000, bc, to, a_s, we_s);
        exp = exp_q.pop_front();
        total++; if (mem_rdata !== exp) begin bad++; $display("[TB] FAIL kbd_rd: got %h want %h", mem_rdata, exp); end
        issue_write(16'h6000, 16'h9999);
        exp_q.push_back(16'h0041);
        issue_read(16'h6000, bc, to, a_s, we_s);
        exp = exp_q.pop_front();
        total++; if (mem_rdata !== exp) begin bad++; $display("[TB] FAIL kbd_ro: got %h want %h", mem_rdata, exp); end
        kbd_code = 16'h0042;
        exp_q.push_back(16'h0042);
        issue_read(16'h6000, bc, to, a_s, we_s);
        exp = exp_q.pop_front();
        total++; if (mem_rdata !== exp) begin bad++; $display("[TB] FAIL kbd_live: got %h want %h", mem_rdata, exp); end
        exp_q.push_back(16'h0000);
        issue_read(16'h7000, bc, to, a_s, we_s);
        exp = exp_q.pop_front();
        total++; if (mem_rdata !== exp) begin bad++; $display("[TB] FAIL unmapped_7000: got %h want %h", mem_rdata, exp); end
        total++; if (mem_busy !== 1'b0) begin bad++; $display("[TB] FAIL unmapped_busy: got %b want 0", mem_busy); end
    endtask

    task automatic test_screen_read();
        logic [15:0] exp;
        int          bc, p0;
        logic        to, we_s;
        logic [12:0] a_s;
        ack_delay = 4;
        fb[5]     = 16'hBEEF;
        p0        = req_pulses;
        exp_q.push_back(16'hBEEF);
        issue_read(16'h4005, bc, to, a_s, we_s);
        exp = exp_q.pop_front();
        total++; if (to || bc != 4) begin bad++; $display("[TB] FAIL scr_miss_busy: got %0d busy cycles want 4", bc); end
        total++; if (a_s !== 13'h0005) begin bad++; $display("[TB] FAIL scr_miss_vaddr: got %h want 0005", a_s); end
        total++; if (we_s !== 1'b0) begin bad++; $display("[TB] FAIL scr_miss_we: got %b want 0", we_s); end
        total++; if (mem_rdata !== exp) begin bad++; $display("[TB] FAIL scr_miss_rdata: got %h want %h", mem_rdata, exp); end
        total++; if (req_pulses != p0 + 1) begin bad++; $display("[TB] FAIL scr_miss_pulses: got %0d want %0d", req_pulses - p0, 1); end
        exp_q.push_back(16'hBEEF);
        issue_read(16'h4005, bc, to, a_s, we_s);
        tick();
        exp = exp_q.pop_front();
        total++; if (bc != 0 || req_pulses != p0 + 1) begin bad++; $display("[TB] FAIL scr_hit_noreq: got busy %0d pulses %0d want 0 1", bc, req_pulses - p0); end
        total++; if (mem_rdata !== exp) begin bad++; $display("[TB] FAIL scr_hit_rdata: got %h want %h", mem_rdata, exp); end
    endtask

    task automatic test_screen_write();
        logic [15:0] exp;
        int          bc, p0;
        logic        to, we_s;
        logic [12:0] a_s;
        ack_delay   = 3;
        p0          = req_pulses;
        mem_address = 16'h5FFF;
        mem_wdata   = 16'hAAAA;
        mem_write   = 1'b1;
        exp_q.push_back(16'hAAAA);
        tick();
        exp = exp_q.pop_front();
        total++; if (vid_req !== 1'b1 || vid_we !== 1'b1) begin bad++; $display("[TB] FAIL scr_wr_req: got req %b we %b want 1 1", vid_req, vid_we); end
        total++; if (vid_addr !== 13'h1FFF) begin bad++; $display("[TB] FAIL scr_wr_vaddr: got %h want 1fff", vid_addr); end
        total++; if (vid_wdata !== 16'hAAAA) begin bad++; $display("[TB] FAIL scr_wr_vwdata: got %h want aaaa", vid_wdata); end
        total++; if (mem_busy !== 1'b1) begin bad++; $display("[TB] FAIL scr_wr_busy: got %b want 1", mem_busy); end
        total++; if (mem_rdata !== exp) begin bad++; $display("[TB] FAIL scr_wr_rdata: got %h want %h", mem_rdata, exp); end
        // CPU keeps the write strobe high and wanders to a RAM address while stalled.
        mem_address = 16'h0010;
        mem_wdata   = 16'h1111;
        bc = 0;
        to = 1'b0;
        while (mem_busy) begin
            if (bc >= 200) begin to = 1'b1; break; end
            total++; if (vid_wdata !== 16'hAAAA || vid_addr !== 13'h1FFF) begin bad++; $display("[TB] FAIL scr_wr_hold: got %h@%h want aaaa@1fff", vid_wdata, vid_addr); end
            tick();
            bc++;
        end
        mem_write = 1'b0;
        total++; if (to || bc != 3) begin bad++; $display("[TB] FAIL scr_wr_busy_len: got %0d want 3", bc); end
        total++; if (req_pulses != p0 + 1) begin bad++; $display("[TB] FAIL scr_wr_once: got %0d pulses want 1", req_pulses - p0); end
        total++; if (fb[13'h1FFF] !== 16'hAAAA) begin bad++; $display("[TB] FAIL scr_wr_fb: got %h want aaaa", fb[13'h1FFF]); end
        exp_q.push_back(16'h5678);
        issue_read(16'h0010, bc, to, a_s, we_s);
        exp = exp_q.pop_front();
        total++; if (mem_rdata !== exp) begin bad++; $display("[TB] FAIL busy_wr_dropped: got %h want %h", mem_rdata, exp); end
        exp_q.push_back(16'hAAAA);
        issue_read(16'h5FFF, bc, to, a_s, we_s);
        tick();
        exp = exp_q.pop_front();
        total++; if (bc != 0 || req_pulses != p0 + 1) begin bad++; $display("[TB] FAIL scr_wr_hit: got busy %0d pulses %0d want 0 1", bc, req_pulses - p0); end
        total++; if (mem_rdata !== exp) begin bad++; $display("[TB] FAIL scr_wr_hit_rdata: got %h want %h", mem_rdata, exp); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp;
        int          bc, p0;
        logic        to, we_s;
        logic [12:0] a_s;
        ack_delay   = 1000;
        mem_address = 16'h4100;
        mem_write   = 1'b0;
        tick();
        total++; if (mem_busy !== 1'b1 || vid_req !== 1'b1) begin bad++; $display("[TB] FAIL mid_start: got busy %b req %b want 1 1", mem_busy, vid_req); end
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (vid_req !== 1'b0 || mem_busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_abort: got req %b busy %b want 0 0", vid_req, mem_busy); end
        ack_delay  = 2;
        fb[13'h100] = 16'h1357;
        p0 = req_pulses;
        exp_q.push_back(16'h1357);
        issue_read(16'h4100, bc, to, a_s, we_s);
        exp = exp_q.pop_front();
        total++; if (to || bc != 2) begin bad++; $display("[TB] FAIL mid_reread_busy: got %0d want 2", bc); end
        total++; if (mem_rdata !== exp) begin bad++; $display("[TB] FAIL mid_reread: got %h want %h", mem_rdata, exp); end
        // The 0x5FFF line was cached before the reset; it must miss now.
        exp_q.push_back(16'hAAAA);
        issue_read(16'h5FFF, bc, to, a_s, we_s);
        exp = exp_q.pop_front();
        total++; if (req_pulses != p0 + 2) begin bad++; $display("[TB] FAIL mid_cache_inval: got %0d pulses want 2", req_pulses - p0); end
        total++; if (mem_rdata !== exp) begin bad++; $display("[TB] FAIL mid_cache_rdata: got %h want %h", mem_rdata, exp); end
    endtask

    task automatic test_ram_boundary();
        logic [15:0] exp;
        int          bc;
        logic        to, we_s;
        logic [12:0] a_s;
        issue_write(16'h0000, 16'h0F0F);
        issue_write(16'h1000, 16'h2222);
        exp_q.push_back(16'h0000);
        issue_read(16'h1000, bc, to, a_s, we_s);
        exp = exp_q.pop_front();
        total++; if (mem_rdata !== exp) begin bad++; $display("[TB] FAIL bound_1000: got %h want %h", mem_rdata, exp); end
        exp_q.push_back(16'h0F0F);
        issue_read(16'h0000, bc, to, a_s, we_s);
        exp = exp_q.pop_front();
        total++; if (mem_rdata !== exp) begin bad++; $display("[TB] FAIL bound_alias: got %h want %h", mem_rdata, exp); end
        exp_q.push_back(16'h0000);
        issue_read(16'h3FFF, bc, to, a_s, we_s);
        exp = exp_q.pop_front();
        total++; if (mem_rdata !== exp) begin bad++; $display("[TB] FAIL bound_3fff: got %h want %h", mem_rdata, exp); end
    endtask

    initial begin
        reset       = 1'b1;
        mem_address = 16'h0;
        mem_write   = 1'b0;
        mem_wdata   = 16'h0;
        kbd_code    = 16'h0;
        vid_rdata   = 16'h0;
        vid_ack     = 1'b0;
        ack_delay   = 2;
        ack_cnt     = 0;
        req_pulses  = 0;
        req_prev    = 1'b0;
        for (int i = 0; i < 8192; i++) fb[i] = 16'h0;
        tick();
        tick();
        tick();
        test_reset();
        reset = 1'b0;
        test_ram();
        test_kbd_unmapped();
        test_screen_read();
        test_screen_write();
        test_reset_mid();
        test_ram_boundary();
        total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
